// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with an occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_en_s;
  logic              wr_en_s;
  logic              flush_s;

  // Accept rules: a write at full only goes through when a read frees a slot.
  always_comb begin
    flush_s = ~rst_n | clr;
    rd_en_s = rd & ~empty_q;
    wr_en_s = wr & (~full_q | rd_en_s);
  end

  // Next-state for pointers, count, read data, sticky errors and status flags.
  always_comb begin
    wr_ptr_d    = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    data_out_d  = rd_en_s ? mem_q[rd_ptr_q] : data_out_q;
    overflow_d  = overflow_q | (wr & ~wr_en_s);
    underflow_d = underflow_q | (rd & empty_q);
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flags are registered from the next count so they move with the count.
    full_d         = (count_d == CW'(DEPTH));
    empty_d        = (count_d == CW'(0));
    almost_full_d  = (count_d >= CW'(AF_THRESH));
    almost_empty_d = (count_d <= CW'(AE_THRESH));
  end

  // Control state; reset and flush both return everything but storage to idle.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_q       <= AW'(0);
      rd_ptr_q       <= AW'(0);
      count_q        <= CW'(0);
      data_out_q     <= DATA_W'(0);
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (!flush_s && wr_en_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at default parameters (8-bit, 16 deep).
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic       clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  logic [7:0] sb_q [$];
  logic [7:0] m_dout;
  int         m_count;
  logic       m_ovf;
  logic       m_udf;

  sync_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .rd           (rd),
    .clr          (clr),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model pushes accepted writes and pops accepted reads.
  task automatic do_cycle(input logic w, input logic r, input logic c,
                          input logic rn, input logic [7:0] d);
    bit rd_acc;
    bit wr_acc;
    rd_acc = r && (m_count != 0);
    wr_acc = w && ((m_count != 16) || rd_acc);
    if (!rn || c) begin
      sb_q.delete();
      m_count = 0;
      m_dout  = 8'h00;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      if (w && !wr_acc) m_ovf = 1'b1;
      if (r && m_count == 0) m_udf = 1'b1;
      if (rd_acc) m_dout = sb_q.pop_front();
      if (wr_acc) sb_q.push_back(d);
      if (wr_acc && !rd_acc) m_count++;
      else if (rd_acc && !wr_acc) m_count--;
    end
    wr = w; rd = r; clr = c; rst_n = rn; data_in = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; rst_n = 1'b1; data_in = 8'h00;
  endtask

  task automatic test_reset();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({data_out, count, empty, full, almost_empty, almost_full, overflow, underflow}
        !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: dout=%h cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want 00 0 1 0 1 0 0 0",
               data_out, count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [8];
    vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd155, 8'd218, 8'd60};
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1, vals[i]);
    checks++;
    if (count !== 5'd8) begin
      failures++;
      $display("FAIL basic_count8: got %0d want 8", count);
    end
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== vals[i] || data_out !== m_dout) begin
        failures++;
        $display("FAIL basic_data[%0d]: got %h want %h", i, data_out, vals[i]);
      end
      checks++;
      if (count !== 5'(7 - i)) begin
        failures++;
        $display("FAIL basic_count[%0d]: got %0d want %0d", i, count, 7 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: empty=%b underflow=%b want 1 0", empty, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(i));
      checks++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) ||
          full !== (i + 1 == 16) || almost_empty !== (i + 1 <= 2) || empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_flags[%0d]: cnt=%0d af=%b f=%b ae=%b e=%b", i, count,
                 almost_full, full, almost_empty, empty);
      end
    end
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || full !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow: cnt=%0d ov=%b f=%b want 16 1 1", count, overflow, full);
    end
  endtask

  task automatic test_full_simul();
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
    checks++;
    if (data_out !== 8'h00 || count !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL full_simul: dout=%h cnt=%0d f=%b want 00 16 1", data_out, count, full);
    end
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== m_dout) begin
        failures++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, data_out, m_dout);
      end
    end
    checks++;
    if (data_out !== 8'hAA || empty !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL wrap_last: dout=%h e=%b un=%b want aa 1 0", data_out, empty, underflow);
    end
  endtask

  task automatic test_underflow();
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (underflow !== 1'b1 || data_out !== 8'hAA || count !== 5'd0 || underflow !== m_udf) begin
      failures++;
      $display("FAIL underflow: un=%b dout=%h cnt=%0d want 1 aa 0", underflow, data_out, count);
    end
  endtask

  task automatic test_empty_simul();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL empty_simul: cnt=%0d un=%b dout=%h want 1 1 00", count, underflow, data_out);
    end
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h55 || data_out !== m_dout || count !== 5'd0) begin
      failures++;
      $display("FAIL empty_simul_read: dout=%h cnt=%0d want 55 0", data_out, count);
    end
  endtask

  // Flush (use_rst=0) or reset (use_rst=1) in the middle of a write burst.
  task automatic test_flush(input bit use_rst);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h3F);
    checks++;
    if (underflow !== 1'b1 || data_out !== 8'h30 || count !== 5'd5) begin
      failures++;
      $display("FAIL flush_setup%0d: un=%b dout=%h cnt=%0d want 1 30 5", use_rst, underflow, data_out, count);
    end
    do_cycle(1'b1, 1'b1, !use_rst, !use_rst, 8'h99);
    checks++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow, data_out}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL flush%0d: cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b dout=%h", use_rst,
               count, empty, full, almost_empty, almost_full, overflow, underflow, data_out);
    end
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h77 || data_out !== m_dout || empty !== 1'b1) begin
      failures++;
      $display("FAIL flush_ptrs%0d: dout=%h e=%b want 77 1", use_rst, data_out, empty);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_count  = 0;
    m_dout   = 8'h00;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    rst_n    = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    clr      = 1'b0;
    data_in  = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_fill();
    test_full_simul();
    test_underflow();
    test_empty_simul();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
